t1_sim_ctrl: RTL and testbench

- Synthesizable simulation-control sequencer for the T1 emulation top.
- Sequences DUT reset release and counts cycles.
- Runs an inter-retire watchdog and a global timeout.
- Arbitrates the finish handshake between the DPI side and the testbench, and reports a watchdog-style status byte.
- Sits beside the clock generator; consumes raw reset and retire events, and drives DUT reset plus pass/fail terminal signals.

---
 rtl/t1_sim_ctrl_pkg.sv | 23 ++
 rtl/t1_sim_ctrl_if.sv | 43 ++++
 rtl/t1_sim_watchdog.sv | 33 +++
 rtl/t1_sim_ctrl.sv | 155 +++++++++++++++
 tb/tb_t1_sim_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/t1_sim_ctrl_pkg.sv
// Shared types and constants for the T1 simulation-control sequencer.
package t1_sim_ctrl_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_e;

  localparam logic [7:0] ST_CONTINUE      = 8'd0;
  localparam logic [7:0] ST_WATCHDOG      = 8'd1;
  localparam logic [7:0] ST_GTIMEOUT      = 8'd2;
  localparam logic [7:0] ST_DONE_MISMATCH = 8'd3;
  localparam logic [7:0] ST_FINISH        = 8'd255;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/t1_sim_ctrl_if.sv
// Config, retire/done events and terminal outputs of the sequencer.
// The dump-window signals exist only when T1_DUMP_WINDOW_EN is defined.
interface t1_sim_ctrl_if #(
  parameter int unsigned CYCLE_W = 64,
  parameter int unsigned WD_W    = 32
);
  logic [WD_W-1:0]    cfg_timeout;
  logic [CYCLE_W-1:0] cfg_global_timeout;
  logic               retire_valid;
  logic               tb_done;
  logic               dpi_done;
  logic               dut_reset;
  logic [CYCLE_W-1:0] cycle;
  logic [7:0]         status;
  logic               finish;
  logic               fatal;

`ifdef T1_DUMP_WINDOW_EN
  logic [CYCLE_W-1:0] cfg_dump_start;
  logic [CYCLE_W-1:0] cfg_dump_end;
  logic               dump_en;

  modport master (
    output cfg_timeout, cfg_global_timeout, retire_valid, tb_done, dpi_done,
           cfg_dump_start, cfg_dump_end,
    input  dut_reset, cycle, status, finish, fatal, dump_en
  );
  modport slave (
    input  cfg_timeout, cfg_global_timeout, retire_valid, tb_done, dpi_done,
           cfg_dump_start, cfg_dump_end,
    output dut_reset, cycle, status, finish, fatal, dump_en
  );
`else
  modport master (
    output cfg_timeout, cfg_global_timeout, retire_valid, tb_done, dpi_done,
    input  dut_reset, cycle, status, finish, fatal
  );
  modport slave (
    input  cfg_timeout, cfg_global_timeout, retire_valid, tb_done, dpi_done,
    output dut_reset, cycle, status, finish, fatal
  );
`endif
endinterface

// File: rtl/t1_sim_watchdog.sv
// Inter-retire watchdog: saturating counter, cleared by kick, compared against cfg_timeout.
module t1_sim_watchdog #(
  parameter int unsigned WD_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            kick,
  input  logic [WD_W-1:0] cfg_timeout,
  output logic            fire_c
);
  logic [WD_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (kick)          cnt_d = '0;
      else if (!(&cnt_q)) cnt_d = cnt_q + WD_W'(1);
    end
  end

  // >= so that a lowered timeout fires immediately on an already-large count.
  assign fire_c = en && !kick && (cfg_timeout != '0) && (cnt_q >= cfg_timeout - WD_W'(1));

endmodule

// File: rtl/t1_sim_ctrl.sv
// Simulation-control sequencer: DUT reset release, cycle count, timeouts, finish arbitration.
// Optional dump window gated by T1_DUMP_WINDOW_EN.
module t1_sim_ctrl
  import t1_sim_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_W      = 64,
  parameter int unsigned WD_W         = 32,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic          clock,
  input  logic          reset,
  t1_sim_ctrl_if.slave  bus
);
  localparam int unsigned HOLD_W  = cnt_w(RESET_CYCLES);
  localparam int unsigned DRAIN_W = cnt_w(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d, cycle_inc_c;
  logic [7:0]         status_q, status_d, err_c;
  logic               tb_seen_q, tb_seen_d, dpi_seen_q, dpi_seen_d;
  logic               dut_reset_q, dut_reset_d, finish_q, finish_d, fatal_q, fatal_d;
  logic               both_c, gto_c, wd_fire_c, wd_clr_c, wd_en_c;

  assign cycle_inc_c = cycle_q + CYCLE_W'(1);
  assign both_c      = (tb_seen_q | bus.tb_done) & (dpi_seen_q | bus.dpi_done);
  assign gto_c       = (bus.cfg_global_timeout != '0) && (cycle_inc_c == bus.cfg_global_timeout);
  assign wd_clr_c    = (state_q == HOLD);
  assign wd_en_c     = (state_q == RUN);

  t1_sim_watchdog #(.WD_W(WD_W)) u_watchdog (
    .clk         (clock),
    .rst_n       (reset),
    .clr         (wd_clr_c),
    .en          (wd_en_c),
    .kick        (bus.retire_valid),
    .cfg_timeout (bus.cfg_timeout),
    .fire_c      (wd_fire_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      drain_q     <= '0;
      cycle_q     <= '0;
      status_q    <= ST_CONTINUE;
      tb_seen_q   <= 1'b0;
      dpi_seen_q  <= 1'b0;
      dut_reset_q <= 1'b1;
      finish_q    <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      drain_q     <= drain_d;
      cycle_q     <= cycle_d;
      status_q    <= status_d;
      tb_seen_q   <= tb_seen_d;
      dpi_seen_q  <= dpi_seen_d;
      dut_reset_q <= dut_reset_d;
      finish_q    <= finish_d;
      fatal_q     <= fatal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    drain_d     = drain_q;
    cycle_d     = cycle_q;
    status_d    = status_q;
    tb_seen_d   = tb_seen_q;
    dpi_seen_d  = dpi_seen_q;
    dut_reset_d = dut_reset_q;
    finish_d    = 1'b0;
    fatal_d     = 1'b0;
    err_c       = ST_CONTINUE;

    case (state_q)
      HOLD: begin
        dut_reset_d = 1'b1;
        if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
          state_d     = RUN;
          dut_reset_d = 1'b0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN, DRAIN: begin
        cycle_d    = cycle_inc_c;
        tb_seen_d  = tb_seen_q | bus.tb_done;
        dpi_seen_d = dpi_seen_q | bus.dpi_done;
        if (gto_c)
          err_c = ST_GTIMEOUT;
        else if (wd_fire_c)
          err_c = ST_WATCHDOG;
        else if ((state_q == DRAIN) && (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)))
          err_c = ST_DONE_MISMATCH;
        // Completion beats any error raised in the same cycle.
        if (both_c) begin
          state_d  = DONE;
          status_d = ST_FINISH;
          finish_d = 1'b1;
        end else if (err_c != ST_CONTINUE) begin
          state_d  = FAIL;
          status_d = err_c;
          fatal_d  = 1'b1;
        end else if ((state_q == RUN) && (tb_seen_d || dpi_seen_d)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else if (state_q == DRAIN) begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.dut_reset = dut_reset_q;
  assign bus.cycle     = cycle_q;
  assign bus.status    = status_q;
  assign bus.finish    = finish_q;
  assign bus.fatal     = fatal_q;

`ifdef T1_DUMP_WINDOW_EN
  logic dump_en_q, dump_en_d, dump_off_q, dump_off_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dump_en_q  <= 1'b0;
      dump_off_q <= 1'b0;
    end else begin
      dump_en_q  <= dump_en_d;
      dump_off_q <= dump_off_d;
    end
  end

  // Window is evaluated on the next cycle value so dump_en lines up with cycle.
  always_comb begin
    dump_en_d  = 1'b0;
    dump_off_d = dump_off_q;
    if ((state_d == RUN) || (state_d == DRAIN)) begin
      if ((bus.cfg_dump_end != '0) && (cycle_d == bus.cfg_dump_end)) dump_off_d = 1'b1;
      dump_en_d = !dump_off_d &&
                  (dump_en_q || ((state_d == RUN) && (cycle_d == bus.cfg_dump_start)));
    end
  end

  assign bus.dump_en = dump_en_q;
`endif

endmodule

// File: tb/tb_t1_sim_ctrl.sv
// Self-checking bench for t1_sim_ctrl: directed and random runs against an event-level model.
module tb_t1_sim_ctrl;
  localparam int unsigned CW = 64;
  localparam int unsigned WW = 32;
  localparam int RC   = 4;
  localparam int DC   = 16;
  localparam int MAXN = 160;

  logic clock = 1'b0;
  logic reset = 1'b0;

  t1_sim_ctrl_if #(.CYCLE_W(CW), .WD_W(WW)) bus ();

  t1_sim_ctrl #(
    .CYCLE_W(CW), .WD_W(WW), .RESET_CYCLES(RC), .DRAIN_CYCLES(DC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  bit          ret_a [MAXN];
  bit          tb_a  [MAXN];
  bit          dp_a  [MAXN];
  int unsigned to_cfg;
  logic [63:0] gto_cfg;
  int          exp_n;
  int          exp_first;
  logic [7:0]  exp_st;
`ifdef T1_DUMP_WINDOW_EN
  logic [63:0] ds_cfg, de_cfg;
`endif

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stim();
    foreach (ret_a[i]) begin
      ret_a[i] = 1'b0;
      tb_a[i]  = 1'b0;
      dp_a[i]  = 1'b0;
    end
    to_cfg  = 0;
    gto_cfg = '0;
`ifdef T1_DUMP_WINDOW_EN
    ds_cfg = '0;
    de_cfg = '0;
`endif
  endtask

  // Outcome from the rules: first cycle where both dones are seen, or the
  // highest-priority error (global timeout, gap since last retire, drain expiry).
  task automatic predict();
    bit tbs;
    bit dps;
    int last;
    tbs = 1'b0; dps = 1'b0; last = -1;
    exp_n = -1; exp_first = -1; exp_st = 8'd0;
    for (int n = 0; n < MAXN; n++) begin
      tbs = tbs | tb_a[n];
      dps = dps | dp_a[n];
      if (tbs && dps) begin
        exp_n = n; exp_st = 8'd255;
        break;
      end
      if (gto_cfg != 0 && 64'(n + 1) == gto_cfg)
        exp_st = 8'd2;
      else if (exp_first < 0 && to_cfg != 0 && !ret_a[n] && (n - last) >= int'(to_cfg))
        exp_st = 8'd1;
      else if (exp_first >= 0 && n == exp_first + DC)
        exp_st = 8'd3;
      if (exp_st != 8'd0) begin
        exp_n = n;
        break;
      end
      if (ret_a[n]) last = n;
      if (exp_first < 0 && (tbs || dps)) exp_first = n;
    end
  endtask

  task automatic drive_idle();
    bus.retire_valid = 1'b0;
    bus.tb_done      = 1'b0;
    bus.dpi_done     = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {bus.dut_reset, bus.cycle, bus.status, bus.finish, bus.fatal},
          {1'b1, 64'd0, 8'd0, 1'b0, 1'b0});
`ifdef T1_DUMP_WINDOW_EN
    check({tag, " dump"}, 128'(bus.dump_en), 128'(1'b0));
`endif
  endtask

  task automatic run_case(input string name, input int abort_at);
    bit running;
    predict();
    bus.cfg_timeout        = to_cfg;
    bus.cfg_global_timeout = gto_cfg;
`ifdef T1_DUMP_WINDOW_EN
    bus.cfg_dump_start = ds_cfg;
    bus.cfg_dump_end   = de_cfg;
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    drive_idle();
    #1 check_reset_vals({name, " reset"});
    @(posedge clock); #1;
    reset = 1'b1;
    for (int k = 0; k < RC; k++) begin
      check($sformatf("%s hold%0d", name, k), {bus.dut_reset, bus.cycle}, {1'b1, 64'd0});
      @(posedge clock); #1;
    end
    for (int n = 0; n < MAXN + 2; n++) begin
      if (n == abort_at) begin
        reset = 1'b0;
        #1 check_reset_vals({name, " abort"});
        break;
      end
      running = (exp_n < 0) ? (n < MAXN) : (n <= exp_n);
      if (running) begin
        check($sformatf("%s run n=%0d", name, n),
              {bus.dut_reset, bus.cycle, bus.status, bus.finish, bus.fatal},
              {1'b0, 64'(n), 8'd0, 1'b0, 1'b0});
      end else if (exp_n >= 0 && n == exp_n + 1) begin
        check({name, " terminal"},
              {bus.dut_reset, bus.cycle, bus.status, bus.finish, bus.fatal},
              {1'b0, 64'(exp_n + 1), exp_st, exp_st == 8'd255, exp_st != 8'd255});
      end else if (exp_n >= 0 && n == exp_n + 2) begin
        check({name, " held"},
              {bus.dut_reset, bus.cycle, bus.status, bus.finish, bus.fatal},
              {1'b0, 64'(exp_n + 1), exp_st, 1'b0, 1'b0});
        break;
      end else begin
        break;
      end
`ifdef T1_DUMP_WINDOW_EN
      check($sformatf("%s dump n=%0d", name, n), 128'(bus.dump_en),
            128'(running && 64'(n) >= ds_cfg && (de_cfg == 0 || 64'(n) < de_cfg) &&
                 (exp_first < 0 || ds_cfg <= 64'(exp_first))));
`endif
      if (n < MAXN) begin
        bus.retire_valid = ret_a[n];
        bus.tb_done      = tb_a[n];
        bus.dpi_done     = dp_a[n];
      end else begin
        drive_idle();
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int t_tb, t_dp;
    drive_idle();
    clear_stim();

    // Watchdog: retire every 5 cycles for 100 cycles, then silence.
    to_cfg = 10;
    for (int n = 0; n < 100; n++) ret_a[n] = (n % 5 == 0);
    run_case("wdog", -1);

    // Global timeout with continuous retires.
    clear_stim();
    to_cfg = 10; gto_cfg = 64'd50;
    foreach (ret_a[i]) ret_a[i] = 1'b1;
    run_case("gto", -1);

    // Both dones on the global-timeout cycle: success wins.
    tb_a[49] = 1'b1; dp_a[49] = 1'b1;
    run_case("gto_vs_done", -1);

    // Staggered dones inside the drain window, with a dump window.
    clear_stim();
    for (int n = 20; n < MAXN; n++) tb_a[n] = 1'b1;
    for (int n = 30; n < MAXN; n++) dp_a[n] = 1'b1;
`ifdef T1_DUMP_WINDOW_EN
    ds_cfg = 64'd5; de_cfg = 64'd9;
`endif
    run_case("drain_ok", -1);

    // Mid-run reset, then the identical sequence again.
    run_case("abort", 10);
    run_case("rerun", -1);

    // dpi_done never arrives.
    foreach (dp_a[i]) dp_a[i] = 1'b0;
    run_case("mismatch", -1);

    for (int r = 0; r < 8; r++) begin
      clear_stim();
      to_cfg  = $urandom_range(0, 15);
      gto_cfg = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(10, 150));
      t_tb = $urandom_range(0, 250);
      t_dp = $urandom_range(0, 250);
      for (int n = 0; n < MAXN; n++) begin
        ret_a[n] = ($urandom_range(0, 3) != 0);
        tb_a[n]  = (n >= t_tb);
        dp_a[n]  = (n >= t_dp);
      end
`ifdef T1_DUMP_WINDOW_EN
      ds_cfg = 64'($urandom_range(0, 20));
      de_cfg = 64'($urandom_range(0, 30));
`endif
      run_case($sformatf("rnd%0d", r), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL time limit: simulation did not reach its summary");
    $fatal(1, "time limit");
  end

endmodule
